// File: rtl/riscv_mem_lsu.sv
// riscv_mem_lsu: load/store unit sitting between the EX stage and a simple
// req/gnt/rvalid memory port. One operation in flight at a time.
// Build macro RISCV_LSU_MISALIGN_CHECK_EN: when defined, misaligned halfword
// and word accesses are faulted (lsu_misalign) instead of being issued.
module riscv_mem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [31:0]           inst_ex_to_mem,
    input  logic [ADDR_WIDTH-1:0] alu_out_data_ex,
    input  logic [DATA_WIDTH-1:0] rs2_data_ex,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  lsu_done,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_misalign
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offs_q, offs_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  misalign_q, misalign_d;

    logic [6:0] in_op;
    logic [2:0] in_f3;
    logic [1:0] in_a;
    logic       in_is_mem, in_store, in_byte, in_half, in_misalign;
    logic       unused_inst_bits;

    assign in_op     = inst_ex_to_mem[6:0];
    assign in_f3     = inst_ex_to_mem[14:12];
    assign in_a      = alu_out_data_ex[1:0];
    assign in_store  = (in_op == OP_STORE);
    assign in_is_mem = (in_op == OP_LOAD) || in_store;
    // Access size comes from funct3[1:0]; 011/110/111 fall through to word.
    assign in_byte   = (in_f3[1:0] == 2'b00);
    assign in_half   = (in_f3[1:0] == 2'b01);
    assign unused_inst_bits = ^{inst_ex_to_mem[31:15], inst_ex_to_mem[11:7]};

`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    assign in_misalign = in_is_mem &&
                         ((in_half && in_a[0]) || (!in_byte && !in_half && (in_a != 2'b00)));
`else
    assign in_misalign = 1'b0;
`endif

    // Strobe is shifted by the full byte offset and truncated, so an unchecked
    // misaligned halfword at offset 3 only enables byte lane 3.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [6:0] wide;
        case (f3[1:0])
            2'b00:   wide = 7'b0000001 << a;
            2'b01:   wide = 7'b0000011 << a;
            default: wide = 7'b0001111;
        endcase
        return wide[3:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (f3[1:0])
            2'b00:   return DATA_WIDTH'({4{d[7:0]}});
            2'b01:   return DATA_WIDTH'({2{d[15:0]}});
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                                       input logic [DATA_WIDTH-1:0] r);
        logic [31:0] lane;
        lane = r[31:0] >> {a, 3'b000};
        case (f3)
            3'b000:  return DATA_WIDTH'({{24{lane[7]}}, lane[7:0]});
            3'b001:  return DATA_WIDTH'({{16{lane[15]}}, lane[15:0]});
            3'b100:  return DATA_WIDTH'({24'd0, lane[7:0]});
            3'b101:  return DATA_WIDTH'({16'd0, lane[15:0]});
            default: return r;
        endcase
    endfunction

    // Next-state and latch logic: capture the operation on accept, wait for
    // gnt/rvalid, then spend one cycle in DONE.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        offs_d     = offs_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (lsu_valid) begin
                    funct3_d   = in_f3;
                    offs_d     = in_a;
                    we_d       = in_store;
                    addr_d     = {alu_out_data_ex[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d    = in_store ? store_data(in_f3, rs2_data_ex) : '0;
                    wstrb_d    = in_store ? store_strb(in_f3, in_a) : 4'b0000;
                    rdata_d    = '0;
                    misalign_d = in_misalign;
                    state_d    = (in_is_mem && !in_misalign) ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_gnt) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = load_ext(funct3_q, offs_q, mem_rdata);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and operation registers; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            offs_q     <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            offs_q     <= offs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign lsu_ready    = (state_q == IDLE);
    assign mem_req      = (state_q == REQ);
    assign lsu_done     = (state_q == DONE);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign lsu_rdata    = rdata_q;
    assign lsu_misalign = misalign_q;

endmodule

// File: tb/tb_riscv_mem_lsu.sv
// Self-checking bench for riscv_mem_lsu: transaction-level reference model,
// per-cycle compare process, directed pins plus randomized operations.
module tb_riscv_mem_lsu;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ADD   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [31:0] inst_ex_to_mem = '0;
    logic [31:0] alu_out_data_ex = '0;
    logic [31:0] rs2_data_ex = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;

    riscv_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .inst_ex_to_mem(inst_ex_to_mem), .alu_out_data_ex(alu_out_data_ex),
        .rs2_data_ex(rs2_data_ex), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_misalign(lsu_misalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectations, written only by the driver.
    bit          chk_en = 1'b0;
    logic        exp_ready = 1'b1, exp_req = 1'b0, exp_done = 1'b0, exp_we = 1'b0, exp_mis = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
    logic [3:0]  exp_strb = '0;
    int          last_lat = 0;

    // Observations, written only by the compare process.
    int          acc_cyc = 0, done_cyc = 0, req_cnt = 0, done_cnt = 0;
    logic [31:0] seen_addr = '0, seen_wdata = '0, seen_rdata = '0;
    logic [3:0]  seen_strb = '0;
    logic        seen_mis = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on byte offsets and access sizes.
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % 4);
        case (acc_size(f3))
            1:       return 4'((1 << off) % 16);
            2:       return 4'((3 << off) % 16);
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (acc_size(f3))
            1:       return (d % 256) * 32'h01010101;
            2:       return (d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] r);
        logic [31:0] v;
        v = r >> (8 * int'(a % 4));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = r;
        endcase
        return v;
    endfunction

    // Compare process: DUT against model expectations on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("lsu_ready", 32'(lsu_ready), 32'(exp_ready));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("lsu_done", 32'(lsu_done), 32'(exp_done));
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) begin
                    chk("mem_wdata", mem_wdata, exp_wdata);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
                end
            end
            if (exp_done) begin
                chk("lsu_rdata", lsu_rdata, exp_rdata);
                chk("lsu_misalign", 32'(lsu_misalign), 32'(exp_mis));
            end
        end
        if (lsu_valid && lsu_ready) acc_cyc = cyc;
        if (mem_req) begin
            req_cnt++;
            seen_addr = mem_addr; seen_wdata = mem_wdata; seen_strb = mem_wstrb;
        end
        if (lsu_done) begin
            done_cnt++;
            done_cyc = cyc; seen_rdata = lsu_rdata; seen_mis = lsu_misalign;
        end
    end

    task automatic set_exp(input logic rdy, input logic req, input logic dn);
        exp_ready = rdy; exp_req = req; exp_done = dn;
    endtask

    // One operation: present, wait gd cycles for gnt, rd cycles for rvalid.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int gd, input int rd, input logic [31:0] rdat);
        logic [31:0] inst;
        logic is_mem, st, mis;
        int exp_lat;
        inst = $urandom; inst[6:0] = op; inst[14:12] = f3;
        is_mem = (op == LOAD) || (op == STORE);
        st = (op == STORE);
        mis = 1'b0;
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
        mis = is_mem && ((a % acc_size(f3)) != 0);
`endif
        exp_addr  = a - (a % 4);
        exp_we    = st;
        exp_wdata = model_wdata(f3, d);
        exp_strb  = model_strb(f3, a);
        exp_rdata = (is_mem && !st && !mis) ? model_load(f3, a, rdat) : 32'd0;
        exp_mis   = mis;
        if (!is_mem || mis) exp_lat = 1;
        else if (st)        exp_lat = gd + 2;
        else                exp_lat = gd + rd + 3;

        lsu_valid = 1'b1; inst_ex_to_mem = inst; alu_out_data_ex = a; rs2_data_ex = d;
        set_exp(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        lsu_valid = 1'($urandom % 2); inst_ex_to_mem = $urandom;
        alu_out_data_ex = $urandom; rs2_data_ex = $urandom;
        if (is_mem && !mis) begin
            for (int i = 0; i <= gd; i++) begin
                mem_gnt = (i == gd); mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
                set_exp(1'b0, 1'b1, 1'b0);
                @(posedge clk); #1;
            end
            mem_gnt = 1'b0;
            if (!st) begin
                for (int j = 0; j <= rd; j++) begin
                    mem_rvalid = (j == rd); mem_rdata = (j == rd) ? rdat : $urandom;
                    set_exp(1'b0, 1'b0, 1'b0);
                    @(posedge clk); #1;
                end
            end
        end
        mem_rvalid = 1'($urandom % 2); mem_gnt = 1'($urandom % 2); mem_rdata = $urandom;
        set_exp(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_gnt = 1'b0; lsu_valid = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0);
        last_lat = done_cyc - acc_cyc;
        chk("latency", 32'(last_lat), 32'(exp_lat));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, 32'(lsu_ready), 32'd1);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_done"}, 32'(lsu_done), 32'd0);
        chk({tag, "_rdata"}, lsu_rdata, 32'd0);
        chk({tag, "_mis"}, 32'(lsu_misalign), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int rq0, dn0;
        logic [6:0] op;
        logic [2:0] f3;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        #1; @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // LW 0x1004, gnt immediately, rvalid next cycle
        do_op(LOAD, 3'b010, 32'h1004, 32'h0, 0, 0, 32'hDEADBEEF);
        chk("lw_rdata", seen_rdata, 32'hDEADBEEF);
        chk("lw_addr", seen_addr, 32'h00001004);
        chk("lw_lat", 32'(last_lat), 32'd3);

        // LB / LBU at byte lane 3
        do_op(LOAD, 3'b000, 32'h2003, 32'h0, 1, 2, 32'h80112233);
        chk("lb_rdata", seen_rdata, 32'hFFFFFF80);
        do_op(LOAD, 3'b100, 32'h2003, 32'h0, 0, 1, 32'h80112233);
        chk("lbu_rdata", seen_rdata, 32'h00000080);

        // SH with delayed grant
        do_op(STORE, 3'b001, 32'h3002, 32'h0000ABCD, 3, 0, 32'h0);
        chk("sh_strb", 32'(seen_strb), 32'h0000000C);
        chk("sh_wdata", seen_wdata, 32'hABCDABCD);
        chk("sh_lat", 32'(last_lat), 32'd5);

        // Non-memory opcode
        rq0 = req_cnt;
        do_op(ADD, 3'b000, 32'h4000, 32'h5555, 0, 0, 32'h0);
        chk("add_noreq", 32'(req_cnt - rq0), 32'd0);
        chk("add_rdata", seen_rdata, 32'd0);
        chk("add_lat", 32'(last_lat), 32'd1);

        // Misaligned word load
        rq0 = req_cnt;
        do_op(LOAD, 3'b010, 32'h1002, 32'h0, 0, 0, 32'h11223344);
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
        chk("mis_flag", 32'(seen_mis), 32'd1);
        chk("mis_noreq", 32'(req_cnt - rq0), 32'd0);
        chk("mis_rdata", seen_rdata, 32'd0);
`else
        chk("mis_addr", seen_addr, 32'h00001000);
        chk("mis_flag", 32'(seen_mis), 32'd0);
        do_op(STORE, 3'b001, 32'h3003, 32'h00001234, 0, 0, 32'h0);
        chk("sh3_strb", 32'(seen_strb), 32'h00000008);
`endif

        // Reset while waiting for load data; late rvalid must be ignored
        chk_en = 1'b0;
        dn0 = done_cnt;
        inst_ex_to_mem = {17'd0, 3'b010, 5'd0, LOAD}; alu_out_data_ex = 32'h1004; lsu_valid = 1'b1;
        @(posedge clk); #1;
        lsu_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk_idle_zero("rstwait0");
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk_idle_zero("rstwait1");
        @(posedge clk); #1;
        chk("rstwait_nodone", 32'(done_cnt - dn0), 32'd0);
        set_exp(1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;

        // Randomized operations
        for (int n = 0; n < 300; n++) begin
            case ($urandom % 8)
                0, 1, 2, 3: begin op = LOAD; f3 = 3'($urandom % 8); end
                4, 5, 6: begin
                    op = STORE;
                    f3 = 3'($urandom % 6);
                    if (f3 == 3'd4) f3 = 3'd6;
                    if (f3 == 3'd5) f3 = 3'd7;
                end
                default: begin
                    op = 7'($urandom);
                    if (op == LOAD || op == STORE) op = ADD;
                    f3 = 3'($urandom % 8);
                end
            endcase
            do_op(op, f3, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
